matvec_result_quant: RTL and testbench
======================================

# matvec_result_quant

Downstream stage of the 8x8 matrix-vector multiplier. Accepts the 28-bit signed dot-product stream over a valid/ready handshake, with optional ReLU, rounding right-shift and saturation to 14-bit signed. Groups every K results into a vector with a last flag. The 14-bit output matches the multiplier's `input_data` format, so layers chain directly.

## Interface
Parameters:
- `K`, 8: results per vector.
- `IW`, 28: input width.
- `OW`, 14: output width.
- `SHW`, 5: shift-amount width.

Ports (single clock `clk`; `reset` is synchronous, active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `input_valid`  in  1  upstream result valid.
- `input_ready`  out  1  block accepts input this cycle.
- `input_data`  in  IW  signed dot-product result.
- `shift`  in  SHW  right-shift amount, 0..IW-1; values ≥IW are treated as IW-1.
- `relu_en`  in  1  clamp negative inputs to 0.
- `output_valid`  out  1  output word valid.
- `output_ready`  in  1  downstream accepts.
- `output_data`  out  OW  signed quantized result.
- `output_last`  out  1  high on element K-1 of each vector.
- `sat_count`  out  16  saturation event counter.

## Operation
- Accept on `input_valid && input_ready`. Transfer out on `output_valid && output_ready`.
- Config latch: `shift` and `relu_en` are captured when element index 0 of a vector is accepted and held for all K elements. Changes mid-vector are ignored until the next vector.
- Element counter `idx`, 0..K-1, advances on each accept and wraps K-1→0. It tags each element's `last = (idx==K-1)`.
- Arithmetic on the accepted word x, using IW+1-bit signed intermediates:
  - r = (relu && x<0) ? 0 : x.
  - rnd = (sh==0) ? 0 : 1<<(sh-1).
  - y = (r + rnd) >>> sh (arithmetic, floor).
- Saturation: if y > 2^(OW-1)-1, the result is 2^(OW-1)-1; if y < -2^(OW-1), the result is -2^(OW-1). Otherwise the result is y[OW-1:0].
- Saturation counting: `sat_count` increments by 1 per accepted element that saturated. It sticks at 0xFFFF and is cleared only by `reset`. ReLU clamping does not count as saturation.
- Two-register pipeline:
  - S1 (compute result) → S2 (output register). `output_*` are driven from S2.
  - S2 loads when `!s2_valid || output_ready`.
  - S1 loads when `!s1_valid` or S1 moves to S2.
  - `input_ready = !s1_valid || (!s2_valid || output_ready)`. This is a combinational path from `output_ready`; it is permitted.
- Reset, including mid-vector:
  - `s1_valid` and `s2_valid` go to 0 and `idx` goes to 0; any partial vector is dropped.
  - Latched config resets to shift=0, relu=0. `sat_count` resets to 0.
  - Outputs after reset: `output_valid`=0, `output_data`=0, `output_last`=0, `sat_count`=0, and `input_ready`=1 from the first post-reset cycle.

## Timing
- Latency: a word accepted at edge t is in S1 after t and presented on `output_*` after edge t+1 (2 cycles), provided S2 is free.
- Throughput: 1 word/cycle while `output_ready`=1.
- Backpressure: with `output_ready`=0 the block holds at most 2 words. `input_ready` drops once both S1 and S2 are full.
- Hold rule: while `output_valid`=1 and `output_ready`=0, `output_data` and `output_last` stay stable.
- Simultaneous events: when S2 drains and a new word is accepted in the same cycle, both happen with no bubble.
- Expected upstream behaviour: 8 results per vector, with gaps allowed between results.

## Structure
- Shared package `matvec_pkg`:
  - constants `K_DEF=8`, `DW_IN=14`, `DW_ACC=28`.
  - typedef `acc_t` (logic signed [27:0]).
  - typedef `elem_t` (logic signed [13:0]).
  - SAT_MAX/SAT_MIN constants.
- Sub-module `quant_sat` (purely combinational): r, rnd, shift and saturate; outputs result and `sat` flag. The top level holds the counter, config latch, S1/S2 registers and handshake.

## Test plan
- shift=4, relu=0, inputs 100, -100, 8, -8, 0, 15, 16, 7 with `output_ready`=1 → outputs 6, -6, 1, 0, 0, 1, 1, 0. `output_last` is set only on the 8th. Each output appears 2 cycles after acceptance.
- shift=0: inputs 0x7FFFFFF and 0x8000000 (−2^27), plus 6 zeros → 8191, -8192, then zeros; `sat_count`=2.
- relu=1, shift=2: inputs -5, 5, -1, 2, 3, -8, 9, 0 → 0, 1, 0, 1, 1, 0, 2, 0 (ties round up); `sat_count`=0.
- Backpressure: `output_ready`=0 while 3 inputs are offered → 2 accepted, then `input_ready`=0 with `output_data` stable. Releasing `output_ready` yields all 3 in order with no loss or duplication.
- Config latch: change `shift` 4→1 at element 3 → elements 0-7 all use shift 4, and element 0 of the next vector uses 1.
- Mid-vector reset after 5 accepts → `output_valid`=0 the next cycle. The next 8 inputs form a full vector, with `output_last` on the 8th.

Source files
------------

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared widths, element types and saturation limits for the matvec datapath
package matvec_pkg;
   localparam int K_DEF  = 8;
   localparam int DW_IN  = 14;
   localparam int DW_ACC = 28;
   typedef logic signed [DW_ACC-1:0] acc_t;
   typedef logic signed [DW_IN-1:0]  elem_t;
   localparam elem_t SAT_MAX = 14'sh1FFF;
   localparam elem_t SAT_MIN = 14'sh2000;
endpackage

// File: rtl/matvec_result_quant_if.sv
// matvec_result_quant_if: input result stream and quantized output stream handshakes
interface matvec_result_quant_if
   import matvec_pkg::*;
#(
   parameter int IW  = DW_ACC,
   parameter int OW  = DW_IN,
   parameter int SHW = 5
);
   logic                  input_valid;
   logic                  input_ready;
   logic signed [IW-1:0]  input_data;
   logic [SHW-1:0]        shift;
   logic                  relu_en;
   logic                  output_valid;
   logic                  output_ready;
   logic signed [OW-1:0]  output_data;
   logic                  output_last;
   modport slave (
      input  input_valid, input_data, shift, relu_en, output_ready,
      output input_ready, output_valid, output_data, output_last
   );
   modport master (
      output input_valid, input_data, shift, relu_en, output_ready,
      input  input_ready, output_valid, output_data, output_last
   );
endinterface

// File: rtl/matvec_result_quant_quant_sat.sv
// quant_sat: optional ReLU, rounding arithmetic right shift and saturation to OW bits
module quant_sat
   import matvec_pkg::*;
#(
   parameter int IW  = DW_ACC,
   parameter int OW  = DW_IN,
   parameter int SHW = 5
) (
   input  logic signed [IW-1:0] x,
   input  logic [SHW-1:0]       sh,
   input  logic                 relu,
   output logic signed [OW-1:0] y,
   output logic                 sat
);
   localparam logic [SHW-1:0]   SH_MAX = SHW'(IW - 1);
   localparam logic signed [IW:0] HI = (IW + 1)'((1 << (OW - 1)) - 1);
   localparam logic signed [IW:0] LO = ~HI;
   logic [SHW-1:0]   s;
   logic signed [IW:0] r, rnd, t;
   // one extra bit of headroom keeps r + rnd from overflowing before the shift
   always_comb begin
      s   = (sh > SH_MAX) ? SH_MAX : sh;
      r   = (relu && x[IW-1]) ? '0 : {x[IW-1], x};
      rnd = (s == '0) ? '0 : (IW + 1)'(1) << (s - 1'b1);
      t   = (r + rnd) >>> s;
      sat = (t > HI) || (t < LO);
      y   = (t > HI) ? HI[OW-1:0] : (t < LO) ? LO[OW-1:0] : t[OW-1:0];
   end
endmodule

// File: rtl/matvec_result_quant.sv
// matvec_result_quant: quantizes the dot-product stream into K-element vectors via a 2-stage pipe
module matvec_result_quant
   import matvec_pkg::*;
#(
   parameter int K   = K_DEF,
   parameter int IW  = DW_ACC,
   parameter int OW  = DW_IN,
   parameter int SHW = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   matvec_result_quant_if.slave         io,
   output logic [15:0]                  sat_count
);
   localparam int XW = $clog2(K);
   localparam logic [XW-1:0] IDX_LAST = XW'(K - 1);
   logic [XW-1:0]        idx_q, idx_d;
   logic [SHW-1:0]       sh_q, sh_d, sh_use;
   logic                 relu_q, relu_d, relu_use;
   logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic                 s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic signed [OW-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, q_y;
   logic [15:0]          sat_q, sat_d;
   logic                 s2_load, s1_move, accept, q_sat;
   // element 0 takes the live config; later elements reuse the value latched with element 0
   always_comb begin
      sh_use   = (idx_q == '0) ? io.shift : sh_q;
      relu_use = (idx_q == '0) ? io.relu_en : relu_q;
   end
   quant_sat #(.IW(IW), .OW(OW), .SHW(SHW)) u_quant_sat (
      .x    (io.input_data),
      .sh   (sh_use),
      .relu (relu_use),
      .y    (q_y),
      .sat  (q_sat)
   );
   // handshake, element counter, config latch, pipeline advance and saturation counter
   always_comb begin
      s2_load        = !s2_valid_q || io.output_ready;
      s1_move        = s1_valid_q && s2_load;
      io.input_ready = !s1_valid_q || s2_load;
      accept         = io.input_valid && io.input_ready;
      idx_d          = accept ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
      sh_d           = (accept && idx_q == '0) ? io.shift : sh_q;
      relu_d         = (accept && idx_q == '0) ? io.relu_en : relu_q;
      s1_valid_d     = accept || (s1_valid_q && !s2_load);
      s1_data_d      = accept ? q_y : s1_data_q;
      s1_last_d      = accept ? (idx_q == IDX_LAST) : s1_last_q;
      s2_valid_d     = s2_load ? s1_valid_q : s2_valid_q;
      s2_data_d      = s1_move ? s1_data_q : s2_data_q;
      s2_last_d      = s1_move ? s1_last_q : s2_last_q;
      sat_d          = (accept && q_sat && sat_q != 16'hFFFF) ? sat_q + 1'b1 : sat_q;
   end
   // state registers; reset drops any partial vector and restores default config
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q      <= '0;
         sh_q       <= '0;
         relu_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         sat_q      <= '0;
      end else begin
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         relu_q     <= relu_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         sat_q      <= sat_d;
      end
   end
   assign io.output_valid = s2_valid_q;
   assign io.output_data  = s2_data_q;
   assign io.output_last  = s2_last_q;
   assign sat_count       = sat_q;
endmodule

// File: tb/tb_matvec_result_quant.sv
// tb_matvec_result_quant: directed and random stimulus against an arithmetic reference model
module tb_matvec_result_quant;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sat_count;
   matvec_result_quant_if io ();
   matvec_result_quant dut (.clk(clk), .reset(reset), .io(io), .sat_count(sat_count));
   always #5 clk = ~clk;
   typedef struct {
      longint d;
      bit     l;
      int     c;
   } exp_t;
   exp_t q[$];
   int   n_vec = 0, n_err = 0, cyc = 0, n_acc = 0;
   int   m_idx = 0, m_sh = 0, m_sat = 0;
   bit   m_relu = 0, lat_mode = 0, last_acc = 0;
   longint t1[8] = '{100, -100, 8, -8, 0, 15, 16, 7};
   longint t3[8] = '{-5, 5, -1, 2, 3, -8, 9, 0};
   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   function automatic void ref_q(input longint x, input int sh, input bit relu, output longint y, output bit s);
      longint r;
      int     k;
      k = (sh > 27) ? 27 : sh;
      r = (relu && x < 0) ? 0 : x;
      if (k > 0) r += longint'(1) << (k - 1);
      r = r >>> k;
      s = (r > 8191) || (r < -8192);
      y = (r > 8191) ? 8191 : (r < -8192) ? -8192 : r;
   endfunction
   task automatic model_clear();
      q.delete();
      m_idx = 0;
      m_sh = 0;
      m_relu = 0;
      m_sat = 0;
   endtask
   task automatic tick();
      exp_t   e;
      longint y;
      bit     s, acc, xfer;
      #1;
      acc  = !reset && io.input_valid && io.input_ready;
      xfer = !reset && io.output_valid && io.output_ready;
      if (xfer) begin
         if (q.size() == 0) chk("spurious_out", q.size(), 1);
         else begin
            e = q.pop_front();
            chk("data", io.output_data, e.d);
            chk("last", io.output_last, e.l);
            if (lat_mode) chk("latency", cyc - e.c, 2);
         end
      end
      if (acc) begin
         if (m_idx == 0) begin
            m_sh = io.shift;
            m_relu = io.relu_en;
         end
         ref_q(longint'(io.input_data), m_sh, m_relu, y, s);
         if (s && m_sat < 65535) m_sat++;
         e.d = y;
         e.l = (m_idx == 7);
         e.c = cyc;
         q.push_back(e);
         m_idx = (m_idx + 1) % 8;
         n_acc++;
      end
      last_acc = acc;
      @(posedge clk);
      cyc++;
      #1;
   endtask
   task automatic send(input longint d, input int sh, input bit relu);
      io.input_valid = 1'b1;
      io.input_data = 28'(d);
      io.shift = 5'(sh);
      io.relu_en = relu;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (last_acc) break;
      end
      if (!last_acc) chk("send_timeout", last_acc, 1);
   endtask
   task automatic drain();
      io.input_valid = 1'b0;
      io.output_ready = 1'b1;
      repeat (5) tick();
      chk("drain_empty", q.size(), 0);
      chk("drain_sat", sat_count, m_sat);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      int n0, v;
      io.input_valid = 1'b0;
      io.input_data = '0;
      io.shift = '0;
      io.relu_en = 1'b0;
      io.output_ready = 1'b1;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      model_clear();
      chk("rst_valid", io.output_valid, 0);
      chk("rst_data", io.output_data, 0);
      chk("rst_last", io.output_last, 0);
      chk("rst_sat", sat_count, 0);
      chk("rst_ready", io.input_ready, 1);
      lat_mode = 1'b1;
      foreach (t1[i]) send(t1[i], 4, 1'b0);
      drain();
      lat_mode = 1'b0;
      send(28'h7FFFFFF, 0, 1'b0);
      send(-134217728, 0, 1'b0);
      repeat (6) send(0, 0, 1'b0);
      drain();
      chk("sat_two", sat_count, 2);
      foreach (t3[i]) send(t3[i], 2, 1'b1);
      drain();
      chk("relu_no_sat", sat_count, 2);
      n0 = n_acc;
      io.output_ready = 1'b0;
      io.input_valid = 1'b1;
      io.shift = 5'd3;
      io.relu_en = 1'b0;
      io.input_data = 28'd11;
      tick();
      io.input_data = 28'd22;
      tick();
      io.input_data = 28'd33;
      tick();
      chk("bp_accepted", n_acc - n0, 2);
      chk("bp_ready", io.input_ready, 0);
      chk("bp_valid", io.output_valid, 1);
      chk("bp_hold0", io.output_data, q[0].d);
      tick();
      tick();
      chk("bp_accepted2", n_acc - n0, 2);
      chk("bp_hold1", io.output_data, q[0].d);
      chk("bp_hold_last", io.output_last, q[0].l);
      io.output_ready = 1'b1;
      send(33, 3, 1'b0);
      repeat (5) send(-77, 3, 1'b0);
      drain();
      for (int i = 0; i < 8; i++) send(100 + i, (i < 3) ? 4 : 1, 1'b0);
      send(100, 1, 1'b0);
      repeat (7) send(50, 1, 1'b0);
      drain();
      repeat (5) send(1000, 2, 1'b0);
      io.input_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      chk("mrst_valid", io.output_valid, 0);
      chk("mrst_ready", io.input_ready, 1);
      chk("mrst_sat", sat_count, 0);
      for (int i = 0; i < 8; i++) send(i * 37 - 100, 1, 1'b0);
      drain();
      for (int i = 0; i < 400; i++) begin
         io.input_valid = ($urandom_range(0, 3) != 0);
         io.output_ready = ($urandom_range(0, 3) != 0);
         io.shift = 5'($urandom_range(0, 31));
         io.relu_en = 1'($urandom_range(0, 1));
         v = int'($urandom_range(0, 4000)) - 2000;
         io.input_data = ($urandom_range(0, 1) == 1) ? 28'($urandom) : 28'(v);
         tick();
      end
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
